// File: rtl/musicbox_pkg.sv
// Shared types and constants for the music-box note loader.
// Optional macro UART_NOTE_PARITY_EN adds an even-parity state to the receiver.
package musicbox_pkg;

`ifdef UART_NOTE_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_WAIT_HIGH
  } rx_state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_WAIT_HIGH
  } rx_state_t;
`endif

  localparam logic [7:0] SYNC_BYTE = 8'hFF;
  localparam int         NOTE_W    = 12;

endpackage

// File: rtl/uart_rx_core.sv
// UART receiver: rx synchronizer, 16x oversample tick generator and frame FSM.
// Macro UART_NOTE_PARITY_EN inserts an even-parity bit between data and stop.
module uart_rx_core
  import musicbox_pkg::*;
#(
  parameter int CLK_HZ = 100000000,
  parameter int BAUD   = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_rx,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_frame_err
);

  localparam int DIV   = CLK_HZ / (BAUD * 16);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  rx_state_t        r_state, w_state_nxt;
  logic             r_rx_s1, r_rx_s2;
  logic [DIV_W-1:0] r_div;
  logic [3:0]       r_tick;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic             r_valid, r_ferr;
  logic             w_rx, w_tick, w_accept, w_reject, w_par_ok;
  logic             w_data_sample;

  assign w_rx   = r_rx_s2;
  assign w_tick = (r_div == DIV_W'(DIV - 1));
  assign w_data_sample = (r_state == ST_DATA) && w_tick && (r_tick == 4'd15);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
    end else begin
      r_rx_s1 <= i_rx;
      r_rx_s2 <= r_rx_s1;
    end
  end

`ifdef UART_NOTE_PARITY_EN
  logic r_par_ok;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_par_ok <= 1'b1;
    else if ((r_state == ST_PARITY) && w_tick && (r_tick == 4'd15))
      r_par_ok <= (w_rx == ^r_shift);
  end
  assign w_par_ok = r_par_ok;
`else
  assign w_par_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    case (r_state)
      ST_IDLE:  if (!w_rx) w_state_nxt = ST_START;
      // Mid-start-bit check filters short glitches without flagging an error
      ST_START: if (w_tick && (r_tick == 4'd7))
                  w_state_nxt = w_rx ? ST_IDLE : ST_DATA;
      ST_DATA:  if (w_data_sample && (r_bit == 3'd7))
`ifdef UART_NOTE_PARITY_EN
                  w_state_nxt = ST_PARITY;
      ST_PARITY: if (w_tick && (r_tick == 4'd15))
`endif
                  w_state_nxt = ST_STOP;
      ST_STOP:  if (w_tick && (r_tick == 4'd15)) begin
                  if (w_rx && w_par_ok) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_IDLE;
                  end else begin
                    w_reject    = 1'b1;
                    w_state_nxt = w_rx ? ST_IDLE : ST_WAIT_HIGH;
                  end
                end
      ST_WAIT_HIGH: if (w_rx) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Tick/bit counters restart on every state change so each sample lands mid-bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div   <= '0;
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_valid <= w_accept;
      r_ferr  <= w_reject;
      if ((r_state == ST_IDLE) || w_tick) r_div <= '0;
      else                                r_div <= r_div + DIV_W'(1);
      if (r_state != w_state_nxt) r_tick <= '0;
      else if (w_tick)            r_tick <= r_tick + 4'd1;
      if (r_state != ST_DATA)     r_bit <= '0;
      else if (w_data_sample)     r_bit <= r_bit + 3'd1;
      if (w_data_sample)          r_shift <= {w_rx, r_shift[7:1]};
    end
  end

  assign o_byte       = r_shift;
  assign o_byte_valid = r_valid;
  assign o_frame_err  = r_ferr;

endmodule

// File: rtl/uart_note_loader.sv
// Loads 12-bit notes from a UART byte stream into a note register file.
// Macro UART_NOTE_PARITY_EN enables even-parity framing in uart_rx_core.
module uart_note_loader
  import musicbox_pkg::*;
#(
  parameter int CLK_HZ = 100000000,
  parameter int BAUD   = 9600,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  output logic [7:0]        read,
  output logic [NOTE_W-1:0] data_c,
  output logic              wen_c,
  output logic [15:0]       addr_c,
  output logic              frame_err
);

  localparam logic [15:0] ADDR_MASK = 16'((32'd1 << ADDR_W) - 32'd1);

  logic [7:0]        w_byte;
  logic              w_valid, w_ferr;
  logic [7:0]        r_read;
  logic [NOTE_W-1:0] r_data;
  logic              r_wen, r_ph;
  logic [3:0]        r_hi;
  logic [15:0]       r_addr;

  uart_rx_core #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_rx (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_rx         (rx),
    .o_byte       (w_byte),
    .o_byte_valid (w_valid),
    .o_frame_err  (w_ferr)
  );

  // Address advances the clock after a write; a sync marker later in the same
  // block takes priority, though the two cannot coincide at any legal baud rate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_read <= '0;
      r_data <= '0;
      r_wen  <= 1'b0;
      r_ph   <= 1'b0;
      r_hi   <= '0;
      r_addr <= '0;
    end else begin
      r_wen <= 1'b0;
      if (r_wen) r_addr <= (r_addr + 16'd1) & ADDR_MASK;
      if (w_ferr) begin
        r_ph <= 1'b0;
      end else if (w_valid) begin
        r_read <= w_byte;
        if (r_ph) begin
          r_data <= {r_hi, w_byte};
          r_wen  <= 1'b1;
          r_ph   <= 1'b0;
        end else if (w_byte == SYNC_BYTE) begin
          r_addr <= '0;
        end else begin
          r_hi <= w_byte[3:0];
          r_ph <= 1'b1;
        end
      end
    end
  end

  assign read      = r_read;
  assign data_c    = r_data;
  assign wen_c     = r_wen;
  assign addr_c    = r_addr;
  assign frame_err = w_ferr;

endmodule
